eater_ctrl_seq: RTL and testbench

Microstep sequencer and instruction decoder for the 8-bit bus computer. It is the control-side counterpart of the adder ALU.
- Drives every bus and register control strobe, including the ALU's out, sub and flag-load inputs.
- Consumes the ALU's registered carry and zero flags for conditional jumps.
- Sits between the instruction register (opcode nibble) and all bus participants.

---
 rtl/eater_pkg.sv | 58 +++++
 rtl/eater_ucode_rom.sv | 87 ++++++++
 rtl/eater_ctrl_seq.sv | 80 ++++++++
 tb/tb_eater_ctrl_seq.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/eater_pkg.sv
// Shared constants for the 8-bit bus computer control path: opcodes,
// control-word bit positions/masks and the microstep count.
package eater_pkg;

    localparam int NSTEPS = 5;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Word layout, MSB first: {hlt,mi,ri,ro,io,ii,ai,ao,eo,su,bi,oi,ce,co,j,fi}
    localparam int B_HLT = 15;
    localparam int B_MI  = 14;
    localparam int B_RI  = 13;
    localparam int B_RO  = 12;
    localparam int B_IO  = 11;
    localparam int B_II  = 10;
    localparam int B_AI  = 9;
    localparam int B_AO  = 8;
    localparam int B_EO  = 7;
    localparam int B_SU  = 6;
    localparam int B_BI  = 5;
    localparam int B_OI  = 4;
    localparam int B_CE  = 3;
    localparam int B_CO  = 2;
    localparam int B_J   = 1;
    localparam int B_FI  = 0;

    function automatic logic [15:0] ctrl_bit(input int idx);
        return 16'h0001 << idx;
    endfunction

    localparam logic [15:0] C_HLT = ctrl_bit(B_HLT);
    localparam logic [15:0] C_MI  = ctrl_bit(B_MI);
    localparam logic [15:0] C_RI  = ctrl_bit(B_RI);
    localparam logic [15:0] C_RO  = ctrl_bit(B_RO);
    localparam logic [15:0] C_IO  = ctrl_bit(B_IO);
    localparam logic [15:0] C_II  = ctrl_bit(B_II);
    localparam logic [15:0] C_AI  = ctrl_bit(B_AI);
    localparam logic [15:0] C_AO  = ctrl_bit(B_AO);
    localparam logic [15:0] C_EO  = ctrl_bit(B_EO);
    localparam logic [15:0] C_SU  = ctrl_bit(B_SU);
    localparam logic [15:0] C_BI  = ctrl_bit(B_BI);
    localparam logic [15:0] C_OI  = ctrl_bit(B_OI);
    localparam logic [15:0] C_CE  = ctrl_bit(B_CE);
    localparam logic [15:0] C_CO  = ctrl_bit(B_CO);
    localparam logic [15:0] C_J   = ctrl_bit(B_J);
    localparam logic [15:0] C_FI  = ctrl_bit(B_FI);

endpackage

// File: rtl/eater_ucode_rom.sv
// Combinational microcode: (opcode, step, flags) -> control word and the
// last active step of the opcode.
module eater_ucode_rom
    import eater_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [2:0]  step,
    input  logic        carry,
    input  logic        zero,
    output logic [15:0] ctrl_word,
    output logic [2:0]  last_step
);

    logic [15:0] exec_s;

    // Execute-phase strobes per opcode; unlisted opcodes behave as NOP.
    always_comb begin
        exec_s    = 16'h0000;
        last_step = 3'd1;
        case (opcode)
            OP_LDA: begin
                last_step = 3'd3;
                case (step)
                    3'd2:    exec_s = C_IO | C_MI;
                    3'd3:    exec_s = C_RO | C_AI;
                    default: exec_s = 16'h0000;
                endcase
            end
            OP_ADD, OP_SUB: begin
                last_step = 3'd4;
                case (step)
                    3'd2:    exec_s = C_IO | C_MI;
                    3'd3:    exec_s = C_RO | C_BI;
                    3'd4:    exec_s = C_EO | C_AI | C_FI | ((opcode == OP_SUB) ? C_SU : 16'h0000);
                    default: exec_s = 16'h0000;
                endcase
            end
            OP_STA: begin
                last_step = 3'd3;
                case (step)
                    3'd2:    exec_s = C_IO | C_MI;
                    3'd3:    exec_s = C_AO | C_RI;
                    default: exec_s = 16'h0000;
                endcase
            end
            OP_LDI: begin
                last_step = 3'd2;
                exec_s    = (step == 3'd2) ? (C_IO | C_AI) : 16'h0000;
            end
            OP_JMP: begin
                last_step = 3'd2;
                exec_s    = (step == 3'd2) ? (C_IO | C_J) : 16'h0000;
            end
            OP_JC: begin
                last_step = 3'd2;
                exec_s    = ((step == 3'd2) && carry) ? (C_IO | C_J) : 16'h0000;
            end
            OP_JZ: begin
                last_step = 3'd2;
                exec_s    = ((step == 3'd2) && zero) ? (C_IO | C_J) : 16'h0000;
            end
            OP_OUT: begin
                last_step = 3'd2;
                exec_s    = (step == 3'd2) ? (C_AO | C_OI) : 16'h0000;
            end
            OP_HLT: begin
                last_step = 3'd2;
                exec_s    = (step == 3'd2) ? C_HLT : 16'h0000;
            end
            default: begin
                last_step = 3'd1;
                exec_s    = 16'h0000;
            end
        endcase
    end

    // Fetch steps are common to every opcode.
    always_comb begin
        ctrl_word = 16'h0000;
        case (step)
            3'd0:    ctrl_word = C_CO | C_MI;
            3'd1:    ctrl_word = C_RO | C_II | C_CE;
            default: ctrl_word = exec_s;
        endcase
    end

endmodule

// File: rtl/eater_ctrl_seq.sv
// Microstep sequencer: step counter, halt latch, and the clr/halt overrides
// applied on top of the microcode ROM output.
module eater_ctrl_seq
    import eater_pkg::*;
#(
    parameter bit EARLY_END = 1'b1,
    parameter int NSTEPS    = eater_pkg::NSTEPS
)(
    input  logic        clk,
    input  logic        clr,
    input  logic        ena,
    input  logic [3:0]  opcode,
    input  logic        carry,
    input  logic        zero,
    output logic [15:0] ctrl,
    output logic [2:0]  step,
    output logic        halted
);

    localparam logic [2:0] FINAL_STEP = 3'(NSTEPS - 1);

    logic [2:0]  step_r;
    logic        halted_r;
    logic [15:0] rom_word_s;
    logic [2:0]  rom_last_s;
    logic        wrap_s;

    eater_ucode_rom u_rom (
        .opcode    (opcode),
        .step      (step_r),
        .carry     (carry),
        .zero      (zero),
        .ctrl_word (rom_word_s),
        .last_step (rom_last_s)
    );

    // Return to fetch after the opcode's last step (early end) or after T4.
    always_comb begin
        wrap_s = 1'b0;
        if ((EARLY_END && (step_r == rom_last_s)) || (step_r == FINAL_STEP)) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
    end

    // Step counter and halt latch; halt freezes the step at T2.
    always_ff @(posedge clk) begin
        if (clr) begin
            step_r   <= 3'd0;
            halted_r <= 1'b0;
        end else if (ena) begin
            if (halted_r) begin
                step_r <= step_r;
            end else if (rom_word_s[B_HLT]) begin
                halted_r <= 1'b1;
            end else if (wrap_s) begin
                step_r <= 3'd0;
            end else begin
                step_r <= step_r + 3'd1;
            end
        end
    end

    // clr silences the bus; a halted machine shows only the hlt strobe.
    always_comb begin
        ctrl = 16'h0000;
        if (clr) begin
            ctrl = 16'h0000;
        end else if (halted_r) begin
            ctrl = C_HLT;
        end else begin
            ctrl = rom_word_s;
        end
    end

    assign step   = step_r;
    assign halted = halted_r;

endmodule

// File: tb/tb_eater_ctrl_seq.sv
// Bench for eater_ctrl_seq: one early-end and one full-length instance fed the
// same stimulus, each checked against a table-driven instruction model.
module tb_eater_ctrl_seq;

    logic        clk;
    logic        clr;
    logic        ena;
    logic [3:0]  opcode;
    logic        carry;
    logic        zero;
    logic [15:0] ctrl_a, ctrl_b;
    logic [2:0]  step_a, step_b;
    logic        halted_a, halted_b;

    int n_cmp = 0;
    int n_bad = 0;

    eater_ctrl_seq #(.EARLY_END(1'b1), .NSTEPS(5)) dut_a (
        .clk(clk), .clr(clr), .ena(ena), .opcode(opcode), .carry(carry), .zero(zero),
        .ctrl(ctrl_a), .step(step_a), .halted(halted_a)
    );

    eater_ctrl_seq #(.EARLY_END(1'b0), .NSTEPS(5)) dut_b (
        .clk(clk), .clr(clr), .ena(ena), .opcode(opcode), .carry(carry), .zero(zero),
        .ctrl(ctrl_b), .step(step_b), .halted(halted_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Instruction table: strobes per step (fetch included) and last active step.
    logic [15:0] tab [16][5];
    int          last_tab [16];
    int          m_step [2];
    bit          m_halt [2];

    function automatic logic [15:0] exp_ctrl(input int k);
        logic [15:0] w;
        if (clr) return 16'h0000;
        if (m_halt[k]) return 16'h8000;
        w = tab[opcode][m_step[k]];
        if (m_step[k] == 2 && opcode == 4'h7 && !carry) w = 16'h0000;
        if (m_step[k] == 2 && opcode == 4'h8 && !zero)  w = 16'h0000;
        return w;
    endfunction

    task automatic model_edge(input int k, input bit early);
        if (clr) begin
            m_step[k] = 0;
            m_halt[k] = 1'b0;
        end else if (ena && !m_halt[k]) begin
            if (opcode == 4'hF && m_step[k] == 2) m_halt[k] = 1'b1;
            else if ((early && m_step[k] == last_tab[opcode]) || m_step[k] == 4) m_step[k] = 0;
            else m_step[k] = m_step[k] + 1;
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] ea, eb;
        ea = exp_ctrl(0);
        eb = exp_ctrl(1);
        n_cmp++;
        assert (ctrl_a === ea) else begin n_bad++; $error("FAIL %s ctrl_ee1 op=%h got=%h exp=%h", tag, opcode, ctrl_a, ea); end
        n_cmp++;
        assert (step_a === 3'(m_step[0])) else begin n_bad++; $error("FAIL %s step_ee1 got=%0d exp=%0d", tag, step_a, m_step[0]); end
        n_cmp++;
        assert (halted_a === m_halt[0]) else begin n_bad++; $error("FAIL %s halted_ee1 got=%0b exp=%0b", tag, halted_a, m_halt[0]); end
        n_cmp++;
        assert (ctrl_b === eb) else begin n_bad++; $error("FAIL %s ctrl_ee0 op=%h got=%h exp=%h", tag, opcode, ctrl_b, eb); end
        n_cmp++;
        assert (step_b === 3'(m_step[1])) else begin n_bad++; $error("FAIL %s step_ee0 got=%0d exp=%0d", tag, step_b, m_step[1]); end
        n_cmp++;
        assert (halted_b === m_halt[1]) else begin n_bad++; $error("FAIL %s halted_ee0 got=%0b exp=%0b", tag, halted_b, m_halt[1]); end
    endtask

    task automatic cyc(input string tag, input logic c, input logic e, input logic [3:0] op,
                       input logic cy, input logic zr);
        clr = c; ena = e; opcode = op; carry = cy; zero = zr;
        #2;
        check_all(tag);
        @(posedge clk);
        model_edge(0, 1'b1);
        model_edge(1, 1'b0);
        #1;
    endtask

    initial begin
        for (int o = 0; o < 16; o++) begin
            for (int s = 0; s < 5; s++) tab[o][s] = 16'h0000;
            tab[o][0] = 16'h4004;          // CO|MI
            tab[o][1] = 16'h1408;          // RO|II|CE
            last_tab[o] = 1;
        end
        tab[1][2] = 16'h4800; tab[1][3] = 16'h1200; last_tab[1] = 3;                       // LDA
        tab[2][2] = 16'h4800; tab[2][3] = 16'h1020; tab[2][4] = 16'h0281; last_tab[2] = 4; // ADD
        tab[3][2] = 16'h4800; tab[3][3] = 16'h1020; tab[3][4] = 16'h02C1; last_tab[3] = 4; // SUB
        tab[4][2] = 16'h4800; tab[4][3] = 16'h2100; last_tab[4] = 3;                       // STA
        tab[5][2] = 16'h0A00; last_tab[5] = 2;                                             // LDI
        tab[6][2] = 16'h0802; last_tab[6] = 2;                                             // JMP
        tab[7][2] = 16'h0802; last_tab[7] = 2;                                             // JC
        tab[8][2] = 16'h0802; last_tab[8] = 2;                                             // JZ
        tab[14][2] = 16'h0110; last_tab[14] = 2;                                           // OUT
        tab[15][2] = 16'h8000; last_tab[15] = 2;                                           // HLT

        clr = 1'b1; ena = 1'b1; opcode = 4'h0; carry = 1'b0; zero = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_step[0] = 0; m_step[1] = 0; m_halt[0] = 1'b0; m_halt[1] = 1'b0;

        cyc("reset", 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("nop", 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);

        cyc("clr", 1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc("sub", 1'b0, 1'b1, 4'h3, 1'b0, 1'b0);

        for (int f = 0; f < 4; f++) begin
            cyc("clr", 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
            for (int i = 0; i < 5; i++)
                cyc("jcjz", 1'b0, 1'b1, (f < 2) ? 4'h7 : 4'h8, f[0], f[0]);
        end

        cyc("clr", 1'b1, 1'b1, 4'h1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("lda", 1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("lda_hold", 1'b0, 1'b0, 4'h1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("lda_resume", 1'b0, 1'b1, 4'h1, 1'b0, 1'b0);

        cyc("clr", 1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) cyc("hlt", 1'b0, 1'b1, 4'hF, 1'b1, 1'b1);
        cyc("hlt_clr", 1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
        cyc("after_clr", 1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc("ldi", 1'b0, 1'b1, 4'h5, 1'b0, 1'b0);

        cyc("clr", 1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("add", 1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
        cyc("add_abort", 1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
        cyc("add_restart", 1'b0, 1'b1, 4'h2, 1'b0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            cyc("rand", ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
